pgaopv_dfpipe: RTL and testbench

PGAOPV_DFPIPE -- requirements
Module: pgaopv_dfpipe

---
 rtl/pgaopv_dfpipe.sv | 91 +++++++++
 tb/tb_pgaopv_dfpipe.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pgaopv_dfpipe.sv
// Elastic register pipeline of DEPTH stages with bubble collapsing, flush and
// occupancy count. Each stage is a clock-enabled data register plus a valid bit.
module pgaopv_dfpipe #(
  parameter int              WIDTH      = 8,
  parameter int              DEPTH      = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit              RESET_DATA = 1'b1
) (
  input  logic                       CP,
  input  logic                       CD,
  input  logic                       FLUSH,
  input  logic                       IN_VLD,
  output logic                       IN_RDY,
  input  logic [WIDTH-1:0]           D,
  output logic                       OUT_VLD,
  input  logic                       OUT_RDY,
  output logic [WIDTH-1:0]           Q,
  output logic [$clog2(DEPTH+1)-1:0] CNT
);

  localparam int CW = $clog2(DEPTH+1);

  // Handshake: a beat moves across a boundary on a rising CP edge exactly when
  // the sender's valid and the receiver's ready are both 1 in the cycle before.
  // OUT_VLD comes straight from a flop; IN_RDY is combinational on OUT_RDY/FLUSH/CD.

  logic [WIDTH-1:0] data_q   [DEPTH];
  logic [WIDTH-1:0] data_src [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_src;
  logic [DEPTH-1:0] acc;
  logic             ripple;
  logic             in_fire;

  // A stage accepts when it is empty or its successor accepts; the chain
  // starts from the downstream ready at the last stage.
  always_comb begin
    ripple = OUT_RDY;
    acc    = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      ripple = ~vld_q[k] | ripple;
      acc[k] = ripple;
    end
  end

  assign IN_RDY  = acc[0] & ~FLUSH & ~CD;
  assign in_fire = IN_VLD & IN_RDY;

  always_comb begin
    data_src[0] = D;
    vld_src[0]  = in_fire;
    for (int k = 1; k < DEPTH; k++) begin
      data_src[k] = data_q[k-1];
      vld_src[k]  = vld_q[k-1];
    end
  end

  always_ff @(posedge CP) begin
    if (CD || FLUSH) begin
      vld_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (acc[k]) vld_q[k] <= vld_src[k];
      end
    end
  end

  // Data only loads on a real beat, so bubbles and flushes leave it untouched.
  always_ff @(posedge CP) begin
    if (CD) begin
      if (RESET_DATA) begin
        for (int k = 0; k < DEPTH; k++) data_q[k] <= RESET_VAL;
      end
    end else if (!FLUSH) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (acc[k] && vld_src[k]) data_q[k] <= data_src[k];
      end
    end
  end

  always_comb begin
    CNT = '0;
    for (int k = 0; k < DEPTH; k++) begin
      CNT = CNT + CW'(vld_q[k]);
    end
  end

  assign OUT_VLD = vld_q[DEPTH-1];
  assign Q       = data_q[DEPTH-1];

endmodule

// File: tb/tb_pgaopv_dfpipe.sv
// Directed bench for pgaopv_dfpipe (WIDTH=8, DEPTH=3, RESET_VAL=8'hA5) with a
// queue scoreboard; a second instance with RESET_DATA=0 shares the inputs.
module tb_pgaopv_dfpipe;

  logic       cp = 1'b0;
  logic       cd, flush, in_vld, out_rdy;
  logic [7:0] d;
  logic       in_rdy, out_vld, in_rdy_nr, out_vld_nr;
  logic [7:0] q, q_nr;
  logic [1:0] cnt, cnt_nr;

  logic [7:0] exp_q[$];
  int         tests = 0;
  int         fails = 0;

  always #5 cp = ~cp;

  pgaopv_dfpipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hA5), .RESET_DATA(1'b1)) dut (
    .CP(cp), .CD(cd), .FLUSH(flush), .IN_VLD(in_vld), .IN_RDY(in_rdy), .D(d),
    .OUT_VLD(out_vld), .OUT_RDY(out_rdy), .Q(q), .CNT(cnt)
  );

  pgaopv_dfpipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hA5), .RESET_DATA(1'b0)) dut_nr (
    .CP(cp), .CD(cd), .FLUSH(flush), .IN_VLD(in_vld), .IN_RDY(in_rdy_nr), .D(d),
    .OUT_VLD(out_vld_nr), .OUT_RDY(out_rdy), .Q(q_nr), .CNT(cnt_nr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] dv, input logic r);
    in_vld  = v;
    d       = dv;
    out_rdy = r;
  endtask

  // Samples the handshakes just before the edge, advances one cycle, then
  // checks occupancy against the number of beats the scoreboard holds.
  task automatic tick();
    logic       clr;
    logic [7:0] e;
    #1;
    clr = cd | flush;
    if (in_vld && in_rdy) exp_q.push_back(d);
    if (out_vld && out_rdy) begin
      if (exp_q.size() == 0) chk("sb_underflow", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        chk("sb_data", q, e);
      end
    end
    @(posedge cp);
    #1;
    if (clr) exp_q.delete();
    chk("cnt", cnt, exp_q.size());
    chk("cnt_nr", cnt_nr, exp_q.size());
  endtask

  initial begin
    cd = 1'b1;
    flush = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    @(posedge cp);
    #1;

    // reset then idle
    chk("rst_in_rdy_low", in_rdy, 0);
    tick();
    cd = 1'b0;
    #1;
    chk("rst_out_vld", out_vld, 0);
    chk("rst_q", q, 8'hA5);
    chk("rst_in_rdy", in_rdy, 1);

    // streaming at full rate
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 8'(i), 1'b1);
      tick();
      if (i == 2) chk("lat_not_yet", out_vld, 0);
      if (i == 3) begin
        chk("lat_vld", out_vld, 1);
        chk("lat_q", q, 8'h01);
      end
      if (i >= 3) chk("stream_cnt3", cnt, 3);
    end
    drive(1'b0, 8'h00, 1'b1);
    repeat (3) tick();
    chk("stream_drained", out_vld, 0);

    // stall with a full pipe, then a simultaneous in/out
    drive(1'b1, 8'h10, 1'b0); tick();
    drive(1'b1, 8'h11, 1'b0); tick();
    drive(1'b1, 8'h12, 1'b0); tick();
    drive(1'b1, 8'h13, 1'b0);
    #1;
    chk("stall_in_rdy", in_rdy, 0);
    tick();
    chk("stall_q0", q, 8'h10);
    chk("stall_vld", out_vld, 1);
    tick();
    chk("stall_q1", q, 8'h10);
    chk("stall_cnt", cnt, 3);
    out_rdy = 1'b1;
    #1;
    chk("stall_rel_in_rdy", in_rdy, 1);
    tick();
    chk("stall_rel_cnt", cnt, 3);
    chk("stall_rel_q", q, 8'h11);
    drive(1'b0, 8'h00, 1'b1);
    repeat (3) tick();

    // bubble between stage 0 and stage 2 collapses forward
    drive(1'b1, 8'h21, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0); tick(); tick();
    drive(1'b1, 8'h22, 1'b0); tick();
    chk("bub_cnt2", cnt, 2);
    chk("bub_q", q, 8'h21);
    drive(1'b0, 8'h00, 1'b0); tick();
    chk("bub_cnt_after", cnt, 2);
    drive(1'b1, 8'h23, 1'b0);
    #1;
    chk("bub_in_rdy", in_rdy, 1);
    tick();
    drive(1'b1, 8'h24, 1'b0);
    #1;
    chk("bub_full", in_rdy, 0);
    drive(1'b0, 8'h00, 1'b1);
    repeat (3) tick();

    // flush a full pipe while a beat is offered
    drive(1'b1, 8'h30, 1'b0); tick();
    drive(1'b1, 8'h31, 1'b0); tick();
    drive(1'b1, 8'h32, 1'b0); tick();
    flush = 1'b1;
    drive(1'b1, 8'h55, 1'b0);
    #1;
    chk("fl_in_rdy", in_rdy, 0);
    tick();
    flush = 1'b0;
    chk("fl_cnt", cnt, 0);
    chk("fl_vld", out_vld, 0);
    chk("fl_q", q, 8'h30);
    drive(1'b0, 8'h00, 1'b0); tick();

    // flush while the head beat is consumed downstream
    drive(1'b1, 8'h41, 1'b0); tick();
    drive(1'b1, 8'h42, 1'b0); tick();
    drive(1'b1, 8'h43, 1'b0); tick();
    flush = 1'b1;
    drive(1'b0, 8'h00, 1'b1);
    tick();
    flush = 1'b0;
    chk("fl_out_vld", out_vld, 0);

    // reset and flush together mid-stream
    drive(1'b1, 8'h50, 1'b0); tick();
    drive(1'b1, 8'h51, 1'b0); tick();
    drive(1'b1, 8'h52, 1'b0); tick();
    chk("pre_rst_q_nr", q_nr, 8'h50);
    cd = 1'b1;
    flush = 1'b1;
    drive(1'b1, 8'h66, 1'b1);
    #1;
    chk("mid_rst_in_rdy", in_rdy, 0);
    tick();
    cd = 1'b0;
    flush = 1'b0;
    chk("mid_rst_vld", out_vld, 0);
    chk("mid_rst_q", q, 8'hA5);
    chk("nr_vld", out_vld_nr, 0);
    chk("nr_q_hold", q_nr, 8'h50);

    // first beat after reset keeps the full latency
    drive(1'b1, 8'h77, 1'b1); tick();
    drive(1'b0, 8'h00, 1'b1); tick();
    chk("post_rst_not_yet", out_vld, 0);
    tick();
    chk("post_rst_vld", out_vld, 1);
    chk("post_rst_q", q, 8'h77);
    tick();
    chk("sb_leftover", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
